// File: rtl/sel_mux_stage_if.sv
// sel_mux_stage_if
//   Bundles the producer side (N channels of data/valid/ready), the select
//   controls and the consumer side of sel_mux_stage.
//   slave  : view taken by the selector itself
//   master : view taken by whoever drives the producers and consumer
//   Ports (all carried as interface signals):
//     in_data   [N*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//     in_valid  [N]        per-channel valid
//     in_ready  [N]        per-channel ready, at most one bit high
//     sel       [SELW]     explicit select (mode=0)
//     mode      [1]        0 = explicit, 1 = round-robin
//     flush     [1]        drop registered output, block acceptance
//     out_data  [WIDTH]    registered selected data
//     out_src   [SELW]     channel that produced out_data
//     out_valid [1]        output register occupied
//     out_ready [1]        consumer accepts this cycle
interface sel_mux_stage_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic               flush;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel, mode, flush, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, sel, mode, flush, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/sel_mux_stage.sv
// sel_mux_stage
//   N-way, WIDTH-bit channel selector feeding a one-entry output register.
//   Channel is chosen either by an explicit select or by round-robin
//   arbitration over the valid channels; the output register supports
//   stall, back-to-back reload and flush.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : sel_mux_stage_if.slave (producer/consumer handshakes + controls)
module sel_mux_stage #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst,
    sel_mux_stage_if.slave bus
);
    localparam int SELW = $clog2(N);

    logic [N-1:0][WIDTH-1:0] w_lanes;
    logic                    w_can_load;
    logic                    w_rr_hit;
    logic [SELW-1:0]         w_rr_idx;
    logic                    w_has_grant;
    logic [SELW-1:0]         w_grant;
    logic [N-1:0]            w_ready;
    logic                    w_xfer;

    logic [WIDTH-1:0]        r_out_data;
    logic [SELW-1:0]         r_out_src;
    logic                    r_out_valid;
    logic [SELW-1:0]         r_ptr;

    assign w_lanes = bus.in_data;

    // Reset also gates acceptance so no producer sees ready while the
    // register is being cleared.
    assign w_can_load = !rst && !bus.flush && (!r_out_valid || bus.out_ready);

    // Round-robin scan: start one past the last served channel and wrap.
    // N is a power of two, so SELW-bit addition wraps for free; k=N lands
    // back on ptr itself as the lowest-priority candidate.
    always_comb begin
        logic [SELW-1:0] idx;
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        idx      = '0;
        for (int k = 1; k <= N; k++) begin
            idx = r_ptr + SELW'(k);
            if (!w_rr_hit && bus.in_valid[idx]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = idx;
            end
        end
    end

    // Explicit mode always grants sel, even if that channel is not valid;
    // the transfer itself still needs in_valid.
    assign w_grant     = bus.mode ? w_rr_idx : bus.sel;
    assign w_has_grant = bus.mode ? w_rr_hit : 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_ready
        assign w_ready[i] = w_can_load && w_has_grant && (w_grant == SELW'(i));
    end

    assign bus.in_ready = w_ready;
    assign w_xfer       = |(w_ready & bus.in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= SELW'(N - 1);
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_lanes[w_grant];
                r_out_src   <= w_grant;
                if (bus.mode) begin
                    r_ptr <= w_grant;
                end
            end else if (bus.flush || bus.out_ready) begin
                // Pop without reload, or flush: data/src keep last values.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_sel_mux_stage.sv
// tb_sel_mux_stage
//   Scoreboard bench: the driver predicts each transfer from a behavioural
//   model and queues the expected {data, src}; an independent monitor pops
//   the queue whenever the consumer takes a word.
module tb_sel_mux_stage;
    localparam int W    = 32;
    localparam int N    = 4;
    localparam int SELW = $clog2(N);

    typedef struct packed {
        logic [W-1:0]    data;
        logic [SELW-1:0] src;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sel_mux_stage_if #(.WIDTH(W), .N(N)) bus ();

    sel_mux_stage #(.WIDTH(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   seen[$];
    logic exp_valid = 1'b0;
    int   mptr = N - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's view of that cycle.
    task automatic step(input logic [N-1:0] v, input logic m, input logic [SELW-1:0] s,
                        input logic f, input logic r, input logic [N*W-1:0] d);
        logic occ, can, has;
        int   g;
        logic [N-1:0] exp_rdy;
        exp_t e;
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = v;
        bus.mode      = m;
        bus.sel       = s;
        bus.flush     = f;
        bus.out_ready = r;
        bus.in_data   = d;
        #1;
        occ       = (q.size() != 0);
        exp_valid = occ;
        can       = !f && (!occ || r);
        has       = 1'b0;
        g         = 0;
        if (!m) begin
            has = 1'b1;
            g   = int'(s);
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (!has && v[c]) begin
                    has = 1'b1;
                    g   = c;
                end
            end
        end
        exp_rdy = '0;
        if (can && has) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        if (f && occ) void'(q.pop_front());
        if (can && has && v[g]) begin
            e.data = d[g*W +: W];
            e.src  = SELW'(g);
            q.push_back(e);
            if (m) mptr = g;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst           = 1'b1;
            bus.in_valid  = '1;
            bus.out_ready = 1'b1;
            bus.flush     = 1'b0;
            #1;
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            if (i > 0) begin
                chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
                chk("rst_out_data",  64'(bus.out_data),  64'd0);
                chk("rst_out_src",   64'(bus.out_src),   64'd0);
            end
        end
        q.delete();
        mptr      = N - 1;
        exp_valid = 1'b0;
    endtask

    // Monitor: samples mid-cycle, after the driver has updated the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("out_valid", 64'(bus.out_valid), 64'(exp_valid));
                if (bus.out_valid && bus.out_ready && !bus.flush) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got src %0d expected no word", bus.out_src);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", 64'(bus.out_data), 64'(e.data));
                        chk("out_src",  64'(bus.out_src),  64'(e.src));
                        seen.push_back(int'(bus.out_src));
                    end
                end
            end
        end
    end

    logic [N*W-1:0] dfix;
    logic [N*W-1:0] drnd;

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.sel       = '0;
        bus.mode      = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) dfix[i*W +: W] = 32'h1000_0000 | 32'(i);

        do_reset(2);

        // Explicit select, stall, back-to-back
        step(4'b1111, 1'b0, 2'd2, 1'b0, 1'b1, dfix);
        step(4'b1111, 1'b0, 2'd1, 1'b0, 1'b1, dfix);
        chk("expl_data_sel2", 64'(bus.out_data), 64'h1000_0002);
        step(4'b1111, 1'b0, 2'd1, 1'b0, 1'b0, dfix);
        chk("expl_data_sel1", 64'(bus.out_data), 64'h1000_0001);
        step(4'b1111, 1'b0, 2'd1, 1'b0, 1'b0, dfix);
        step(4'b1111, 1'b0, 2'd1, 1'b0, 1'b0, dfix);
        chk("stall_hold", 64'(bus.out_data), 64'h1000_0001);
        step(4'b1111, 1'b0, 2'd3, 1'b0, 1'b1, dfix);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, dfix);
        chk("b2b_data", 64'(bus.out_data), 64'h1000_0003);
        step(4'b1000, 1'b0, 2'd0, 1'b0, 1'b1, dfix);

        // Round-robin fairness
        do_reset(2);
        seen.delete();
        repeat (8) step(4'b1111, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        repeat (2) step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        chk("rr_fair_count", 64'(seen.size()), 64'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("rr_fair_src", 64'(seen[i]), 64'(i % 4));

        // Round-robin skip and wrap
        do_reset(2);
        seen.delete();
        repeat (4) step(4'b1001, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        repeat (2) step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        chk("rr_skip_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("rr_skip_src", 64'(seen[i]), (i % 2 == 0) ? 64'd0 : 64'd3);

        // Flush while stalled; ptr must hold so channel 1 is served next
        do_reset(2);
        seen.delete();
        step(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, dfix);
        step(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, dfix);
        step(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, dfix);
        step(4'b1111, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, dfix);
        chk("flush_next_src", 64'(bus.out_src), 64'd1);
        step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b1, dfix);

        // Randomised traffic, with one reset in the middle of a stream
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) drnd[i*W +: W] = $urandom;
            if (n == 200) do_reset(2);
            step(N'($urandom), 1'($urandom), SELW'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), drnd);
        end
        repeat (3) step('0, 1'b0, '0, 1'b0, 1'b1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
